// File: rtl/hw_supervisor_pkg.sv
// Shared types, status codes and status_word layout for the hardware supervisor.
package hw_supervisor_pkg;

  localparam int unsigned BOARD_W = 4;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned TIMER_W = 32;
  localparam int unsigned N_VEC_CLASSES = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHDN_RST  = 3'd1,
    ST_START_DMA = 3'd2,
    ST_START_SPI = 3'd3,
    ST_RUNNING   = 3'd4,
    ST_STOPPING  = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  localparam logic [CODE_W-1:0] CODE_NONE         = 8'h00;
  localparam logic [CODE_W-1:0] CODE_SYS_DIS      = 8'h01;
  localparam logic [CODE_W-1:0] CODE_DMA_TO       = 8'h02;
  localparam logic [CODE_W-1:0] CODE_SPI_START_TO = 8'h03;
  localparam logic [CODE_W-1:0] CODE_OVER_THRESH  = 8'h04;
  localparam logic [CODE_W-1:0] CODE_SHDN_SENSE   = 8'h05;
  localparam logic [CODE_W-1:0] CODE_EXT_SHDN     = 8'h06;
  localparam logic [CODE_W-1:0] CODE_DAC_EMPTY    = 8'h07;
  localparam logic [CODE_W-1:0] CODE_ADC_FULL     = 8'h08;
  localparam logic [CODE_W-1:0] CODE_PREMAT_TRIG  = 8'h09;
  localparam logic [CODE_W-1:0] CODE_PREMAT_DAC   = 8'h0A;
  localparam logic [CODE_W-1:0] CODE_PREMAT_ADC   = 8'h0B;
  localparam logic [CODE_W-1:0] CODE_STOP_TO      = 8'h0C;

  localparam int unsigned SW_RUNNING     = 31;
  localparam int unsigned SW_STOPPING    = 30;
  localparam int unsigned SW_DMA_RUNNING = 29;
  localparam int unsigned SW_SPI_RUNNING = 28;
  localparam int unsigned SW_HALTED      = 27;
  localparam int unsigned SW_BOARD_LSB   = 23;
  localparam int unsigned SW_CODE_LSB    = 0;

  typedef struct packed {
    logic sys_rst;
    logic dma_en;
    logic spi_en;
    logic n_sck_pow;
    logic shutdown_force;
    logic n_shutdown_rst;
    logic running;
    logic stopping;
    logic dma_running;
    logic halted;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    sys_rst: 1'b1, dma_en: 1'b0, spi_en: 1'b0, n_sck_pow: 1'b1,
    shutdown_force: 1'b1, n_shutdown_rst: 1'b1, running: 1'b0,
    stopping: 1'b0, dma_running: 1'b0, halted: 1'b0
  };

  // Force the hardware into its safe configuration, keeping the other flags
  function automatic ctl_t safe_ctl(input ctl_t c);
    ctl_t s;
    s                = c;
    s.sys_rst        = 1'b1;
    s.dma_en         = 1'b0;
    s.dma_running    = 1'b0;
    s.spi_en         = 1'b0;
    s.n_sck_pow      = 1'b1;
    s.shutdown_force = 1'b1;
    s.running        = 1'b0;
    s.stopping       = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/hw_supervisor_lsb_index.sv
// Lowest-set-bit locator used to name the first board of a vector fault class.
module lsb_index
  import hw_supervisor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   vec,
  output logic [BOARD_W-1:0] idx_c,
  output logic               valid_c
);

  // Scan from the top so the last hit written is the lowest index
  always_comb begin
    idx_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = BOARD_W'(i);
    end
  end

  assign valid_c = |vec;

endmodule

// File: rtl/hw_supervisor.sv
// Start-up / shutdown sequencer for the board array with prioritised fault capture.
module hw_supervisor
  import hw_supervisor_pkg::*;
#(
  parameter int unsigned N_BOARDS        = 8,
  parameter int unsigned BUF_LOAD_WAIT   = 250000000,
  parameter int unsigned SPI_START_WAIT  = 250000000,
  parameter int unsigned SPI_STOP_WAIT   = 250000000,
  parameter int unsigned SHDN_RST_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sys_en,
  input  logic [7:0]          fault_mask,
  input  logic                dac_buf_full,
  input  logic                spi_running,
  input  logic                ext_shutdown,
  input  logic                shutdown_sense,
  input  logic [3:0]          sense_num,
  input  logic [N_BOARDS-1:0] over_thresh,
  input  logic [N_BOARDS-1:0] dac_empty_read,
  input  logic [N_BOARDS-1:0] adc_full_write,
  input  logic [N_BOARDS-1:0] premat_trig,
  input  logic [N_BOARDS-1:0] premat_dac_div,
  input  logic [N_BOARDS-1:0] premat_adc_div,
  output logic                sys_rst,
  output logic                dma_en,
  output logic                spi_en,
  output logic                n_sck_pow,
  output logic                shutdown_force,
  output logic                n_shutdown_rst,
  output logic [N_BOARDS-1:0] fault_boards,
  output logic [31:0]         status_word
);

  state_t              state, state_d;
  ctl_t                ctl, ctl_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [CODE_W-1:0]   status_code, code_d, cap_code;
  logic [BOARD_W-1:0]  board_num, board_d, cap_board;
  logic [N_BOARDS-1:0] fb_d, cap_fb;
  logic                prev_sys_en, prev_d;
  logic                unused_mask_bit;

  logic [N_BOARDS-1:0]      vec_flt [N_VEC_CLASSES];
  logic [BOARD_W-1:0]       vec_idx [N_VEC_CLASSES];
  logic [N_VEC_CLASSES-1:0] vec_hit;

  assign unused_mask_bit = fault_mask[7];

  assign vec_flt[0] = over_thresh;
  assign vec_flt[1] = dac_empty_read;
  assign vec_flt[2] = adc_full_write;
  assign vec_flt[3] = premat_trig;
  assign vec_flt[4] = premat_dac_div;
  assign vec_flt[5] = premat_adc_div;

  for (genvar g = 0; g < N_VEC_CLASSES; g++) begin : g_lsb
    lsb_index #(.WIDTH(N_BOARDS)) u_lsb (
      .vec     (vec_flt[g]),
      .idx_c   (vec_idx[g]),
      .valid_c (vec_hit[g])
    );
  end

  // Highest-priority unmasked fault cause while running
  always_comb begin
    cap_code  = CODE_NONE;
    cap_board = board_num;
    cap_fb    = '0;
    if (!sys_en) begin
      cap_code = CODE_SYS_DIS;
    end else if (vec_hit[0] && !fault_mask[0]) begin
      cap_code = CODE_OVER_THRESH;  cap_board = vec_idx[0]; cap_fb = over_thresh;
    end else if (shutdown_sense && !fault_mask[1]) begin
      cap_code = CODE_SHDN_SENSE;   cap_board = sense_num;
    end else if (ext_shutdown && !fault_mask[2]) begin
      cap_code = CODE_EXT_SHDN;
    end else if (vec_hit[1] && !fault_mask[3]) begin
      cap_code = CODE_DAC_EMPTY;    cap_board = vec_idx[1]; cap_fb = dac_empty_read;
    end else if (vec_hit[2] && !fault_mask[4]) begin
      cap_code = CODE_ADC_FULL;     cap_board = vec_idx[2]; cap_fb = adc_full_write;
    end else if (vec_hit[3] && !fault_mask[5]) begin
      cap_code = CODE_PREMAT_TRIG;  cap_board = vec_idx[3]; cap_fb = premat_trig;
    end else if (vec_hit[4] && !fault_mask[6]) begin
      cap_code = CODE_PREMAT_DAC;   cap_board = vec_idx[4]; cap_fb = premat_dac_div;
    end else if (vec_hit[5]) begin
      cap_code = CODE_PREMAT_ADC;   cap_board = vec_idx[5]; cap_fb = premat_adc_div;
    end
  end

  // Next-state and next-output logic; timer restarts at zero on every state change
  always_comb begin
    state_d = state;
    ctl_d   = ctl;
    timer_d = '0;
    code_d  = status_code;
    board_d = board_num;
    fb_d    = fault_boards;
    prev_d  = prev_sys_en;
    case (state)
      ST_IDLE: begin
        prev_d = sys_en;
        if (sys_en && !prev_sys_en) begin
          state_d              = ST_SHDN_RST;
          ctl_d.sys_rst        = 1'b0;
          ctl_d.shutdown_force = 1'b0;
          ctl_d.n_shutdown_rst = 1'b0;
          ctl_d.running        = 1'b1;
          code_d               = CODE_NONE;
          board_d              = '0;
          fb_d                 = '0;
        end
      end
      ST_SHDN_RST: begin
        if (timer == TIMER_W'(SHDN_RST_CYCLES - 1)) begin
          state_d              = ST_START_DMA;
          ctl_d.n_shutdown_rst = 1'b1;
          ctl_d.dma_en         = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_START_DMA: begin
        if (!sys_en) begin
          state_d = ST_IDLE;
          code_d  = CODE_SYS_DIS;
          ctl_d   = safe_ctl(ctl);
        end else if (dac_buf_full) begin
          state_d           = ST_START_SPI;
          ctl_d.dma_running = 1'b1;
          ctl_d.spi_en      = 1'b1;
          ctl_d.n_sck_pow   = 1'b0;
        end else if (timer == TIMER_W'(BUF_LOAD_WAIT)) begin
          state_d      = ST_HALTED;
          code_d       = CODE_DMA_TO;
          ctl_d        = safe_ctl(ctl);
          ctl_d.halted = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_START_SPI: begin
        if (!sys_en) begin
          state_d        = ST_STOPPING;
          code_d         = CODE_SYS_DIS;
          ctl_d.stopping = 1'b1;
          ctl_d.spi_en   = 1'b0;
        end else if (spi_running) begin
          state_d = ST_RUNNING;
        end else if (timer == TIMER_W'(SPI_START_WAIT)) begin
          state_d      = ST_HALTED;
          code_d       = CODE_SPI_START_TO;
          ctl_d        = safe_ctl(ctl);
          ctl_d.halted = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_RUNNING: begin
        if (cap_code != CODE_NONE) begin
          state_d        = ST_STOPPING;
          ctl_d.stopping = 1'b1;
          ctl_d.spi_en   = 1'b0;
          code_d         = cap_code;
          board_d        = cap_board;
          fb_d           = cap_fb;
        end
      end
      ST_STOPPING: begin
        if (!spi_running) begin
          state_d = ST_IDLE;
          ctl_d   = safe_ctl(ctl);
        end else if (timer == TIMER_W'(SPI_STOP_WAIT)) begin
          state_d      = ST_HALTED;
          code_d       = CODE_STOP_TO;
          ctl_d        = safe_ctl(ctl);
          ctl_d.halted = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_HALTED: begin
        if (!sys_en) begin
          state_d      = ST_IDLE;
          ctl_d.halted = 1'b0;
          prev_d       = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctl_d   = safe_ctl(ctl);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ctl          <= CTL_RESET;
      timer        <= '0;
      status_code  <= CODE_NONE;
      board_num    <= '0;
      fault_boards <= '0;
      prev_sys_en  <= 1'b1;
    end else begin
      state        <= state_d;
      ctl          <= ctl_d;
      timer        <= timer_d;
      status_code  <= code_d;
      board_num    <= board_d;
      fault_boards <= fb_d;
      prev_sys_en  <= prev_d;
    end
  end

  assign sys_rst        = ctl.sys_rst;
  assign dma_en         = ctl.dma_en;
  assign spi_en         = ctl.spi_en;
  assign n_sck_pow      = ctl.n_sck_pow;
  assign shutdown_force = ctl.shutdown_force;
  assign n_shutdown_rst = ctl.n_shutdown_rst;

  // spi_running is reported live, but the word must read zero while in reset
  always_comb begin
    status_word                              = '0;
    status_word[SW_RUNNING]                  = ctl.running;
    status_word[SW_STOPPING]                 = ctl.stopping;
    status_word[SW_DMA_RUNNING]              = ctl.dma_running;
    status_word[SW_SPI_RUNNING]              = spi_running & ~rst;
    status_word[SW_HALTED]                   = ctl.halted;
    status_word[SW_BOARD_LSB +: BOARD_W]     = board_num;
    status_word[SW_CODE_LSB +: CODE_W]       = status_code;
  end

endmodule

// File: tb/tb_hw_supervisor.sv
// Directed plus randomized checks of hw_supervisor against a priority-table model.
module tb_hw_supervisor;

  localparam int unsigned NB = 8;

  logic          clk;
  logic          rst;
  logic          sys_en;
  logic [7:0]    fault_mask;
  logic          dac_buf_full;
  logic          spi_running;
  logic          ext_shutdown;
  logic          shutdown_sense;
  logic [3:0]    sense_num;
  logic [NB-1:0] over_thresh, dac_empty_read, adc_full_write;
  logic [NB-1:0] premat_trig, premat_dac_div, premat_adc_div;
  logic          sys_rst, dma_en, spi_en, n_sck_pow, shutdown_force, n_shutdown_rst;
  logic [NB-1:0] fault_boards;
  logic [31:0]   status_word;

  int total = 0;
  int bad   = 0;

  hw_supervisor #(
    .N_BOARDS(NB), .BUF_LOAD_WAIT(20), .SPI_START_WAIT(20),
    .SPI_STOP_WAIT(20), .SHDN_RST_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .sys_en(sys_en), .fault_mask(fault_mask),
    .dac_buf_full(dac_buf_full), .spi_running(spi_running),
    .ext_shutdown(ext_shutdown), .shutdown_sense(shutdown_sense),
    .sense_num(sense_num), .over_thresh(over_thresh),
    .dac_empty_read(dac_empty_read), .adc_full_write(adc_full_write),
    .premat_trig(premat_trig), .premat_dac_div(premat_dac_div),
    .premat_adc_div(premat_adc_div), .sys_rst(sys_rst), .dma_en(dma_en),
    .spi_en(spi_en), .n_sck_pow(n_sck_pow), .shutdown_force(shutdown_force),
    .n_shutdown_rst(n_shutdown_rst), .fault_boards(fault_boards),
    .status_word(status_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Status word assembled from its documented fields
  function automatic logic [31:0] sw(input bit run, input bit stop, input bit dmar,
                                     input bit spir, input bit halt,
                                     input logic [3:0] board, input logic [7:0] code);
    return (32'(run) << 31) | (32'(stop) << 30) | (32'(dmar) << 29) |
           (32'(spir) << 28) | (32'(halt) << 27) | (32'(board) << 23) | 32'(code);
  endfunction

  function automatic logic [3:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Priority table: entry k is code 4+k; mask bit k applies to entries 0..6
  function automatic void predict(output logic [7:0] code, output logic [3:0] board,
                                  output logic [7:0] fb);
    logic [7:0] cls [8];
    cls = '{over_thresh, {7'b0, shutdown_sense}, {7'b0, ext_shutdown}, dac_empty_read,
            adc_full_write, premat_trig, premat_dac_div, premat_adc_div};
    code = 8'h00; board = 4'd0; fb = 8'h00;
    if (!sys_en) begin
      code = 8'h01;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      if (cls[k] != 8'h00 && !(k < 7 && fault_mask[k])) begin
        code = 8'(4 + k);
        if (k == 1) board = sense_num;
        else if (k != 2) begin
          board = lowest(cls[k]);
          fb    = cls[k];
        end
        return;
      end
    end
  endfunction

  task automatic clear_faults();
    fault_mask = 8'h00; ext_shutdown = 1'b0; shutdown_sense = 1'b0; sense_num = 4'd0;
    over_thresh = '0; dac_empty_read = '0; adc_full_write = '0;
    premat_trig = '0; premat_dac_div = '0; premat_adc_div = '0;
  endtask

  function automatic logic [7:0] rvec();
    return ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
  endfunction

  task automatic randomize_faults();
    sys_en         = ($urandom_range(0, 7) != 0);
    fault_mask     = 8'($urandom);
    ext_shutdown   = ($urandom_range(0, 3) == 0);
    shutdown_sense = ($urandom_range(0, 3) == 0);
    sense_num      = 4'($urandom);
    over_thresh    = rvec(); dac_empty_read = rvec(); adc_full_write = rvec();
    premat_trig    = rvec(); premat_dac_div = rvec(); premat_adc_div = rvec();
  endtask

  // Bring the block from IDLE to RUNNING with prompt handshakes
  task automatic start_run();
    sys_en = 1'b0; dac_buf_full = 1'b0; spi_running = 1'b0;
    clear_faults();
    step(); step();
    sys_en = 1'b1;
    for (int i = 0; i < 100 && dma_en !== 1'b1; i++) step();
    chk("run_dma_en", 32'(dma_en), 32'd1);
    dac_buf_full = 1'b1;
    step();
    chk("run_spi_en", 32'(spi_en), 32'd1);
    dac_buf_full = 1'b0; spi_running = 1'b1;
    step();
    chk("run_status", status_word, 32'hB000_0000);
  endtask

  task automatic apply_check(input string tag, output logic [7:0] c,
                             output logic [3:0] b, output logic [7:0] f);
    predict(c, b, f);
    step();
    if (c != 8'h00) begin
      chk({tag, "_code"}, 32'(status_word[7:0]), 32'(c));
      chk({tag, "_board"}, 32'(status_word[26:23]), 32'(b));
      chk({tag, "_fb"}, 32'(fault_boards), 32'(f));
      chk({tag, "_spi_en"}, 32'(spi_en), 32'd0);
      chk({tag, "_sw"}, status_word, sw(1, 1, 1, spi_running, 0, b, c));
    end else begin
      chk({tag, "_hold_sw"}, status_word, 32'hB000_0000);
      chk({tag, "_hold_spi_en"}, 32'(spi_en), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] c, f;
    logic [3:0] b;
    int cnt;

    rst = 1'b1; sys_en = 1'b0; dac_buf_full = 1'b0; spi_running = 1'b0;
    clear_faults();
    step(); step();
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_shdn_force", 32'(shutdown_force), 32'd1);
    chk("rst_n_shdn_rst", 32'(n_shutdown_rst), 32'd1);
    chk("rst_n_sck_pow", 32'(n_sck_pow), 32'd1);
    chk("rst_dma_spi", {30'd0, dma_en, spi_en}, 32'd0);
    chk("rst_status", status_word, 32'd0);
    rst = 1'b0;
    step();

    // Nominal start: 16-cycle shutdown reset, slow buffer load, slow SPI start
    sys_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!n_shutdown_rst) cnt++;
      else if (cnt != 0) break;
    end
    chk("nom_shdn_low_cycles", 32'(cnt), 32'd16);
    chk("nom_dma_en", 32'(dma_en), 32'd1);
    repeat (10) step();
    chk("nom_wait_spi_en", 32'(spi_en), 32'd0);
    dac_buf_full = 1'b1;
    step();
    chk("nom_spi_en", 32'(spi_en), 32'd1);
    chk("nom_n_sck_pow", 32'(n_sck_pow), 32'd0);
    dac_buf_full = 1'b0;
    repeat (5) step();
    spi_running = 1'b1;
    step();
    chk("nom_running", status_word, 32'hB000_0000);

    // Simultaneous faults: over_thresh outranks premat_trig
    over_thresh = 8'h28; premat_trig = 8'h01;
    apply_check("prio", c, b, f);
    chk("prio_code_const", 32'(status_word[7:0]), 32'h04);
    chk("prio_board_const", 32'(status_word[26:23]), 32'd3);
    clear_faults(); spi_running = 1'b0;
    step();
    chk("prio_idle_sys_rst", 32'(sys_rst), 32'd1);
    chk("prio_idle_sw", status_word, sw(0, 0, 0, 0, 0, 4'd3, 8'h04));
    repeat (3) step();
    chk("prio_no_restart", 32'(n_shutdown_rst), 32'd1);

    // Masked over_thresh lets ext_shutdown through
    start_run();
    fault_mask = 8'h01; over_thresh = 8'h01; ext_shutdown = 1'b1;
    apply_check("mask", c, b, f);
    chk("mask_code_const", 32'(status_word[7:0]), 32'h06);
    clear_faults(); spi_running = 1'b0;
    step();

    // Randomized fault patterns against the priority table
    for (int it = 0; it < 8; it++) begin
      start_run();
      c = 8'h00;
      for (int t = 0; t < 4 && c == 8'h00; t++) begin
        randomize_faults();
        apply_check("rnd", c, b, f);
        if (c == 8'h00) clear_faults();
      end
      if (c == 8'h00) begin
        sys_en = 1'b0;
        apply_check("rnd_sysdis", c, b, f);
      end
      clear_faults(); spi_running = 1'b0;
      step();
      chk("rnd_idle_sw", status_word, sw(0, 0, 0, 0, 0, b, c));
      chk("rnd_idle_fb", 32'(fault_boards), 32'(f));
      chk("rnd_idle_sys_rst", 32'(sys_rst), 32'd1);
    end

    // Buffer-load timeout: 21 START_DMA cycles then HALTED
    sys_en = 1'b0; dac_buf_full = 1'b0; spi_running = 1'b0;
    step(); step();
    sys_en = 1'b1;
    for (int i = 0; i < 100 && dma_en !== 1'b1; i++) step();
    cnt = 0;
    for (int i = 0; i < 100 && dma_en === 1'b1; i++) begin
      cnt++;
      step();
    end
    chk("dma_to_cycles", 32'(cnt), 32'd21);
    chk("dma_to_sw", status_word, sw(0, 0, 0, 0, 1, 4'd0, 8'h02));
    chk("dma_to_sys_rst", 32'(sys_rst), 32'd1);
    repeat (5) step();
    chk("halt_hold_sw", status_word, sw(0, 0, 0, 0, 1, 4'd0, 8'h02));
    sys_en = 1'b0;
    step();
    chk("halt_exit_sw", status_word, sw(0, 0, 0, 0, 0, 4'd0, 8'h02));

    // sys_en dropped during START_DMA returns to IDLE
    step();
    sys_en = 1'b1;
    for (int i = 0; i < 100 && dma_en !== 1'b1; i++) step();
    sys_en = 1'b0;
    step();
    chk("dma_abort_sw", status_word, sw(0, 0, 0, 0, 0, 4'd0, 8'h01));
    chk("dma_abort_dma_en", 32'(dma_en), 32'd0);

    // STOPPING timeout with spi_running stuck high
    start_run();
    ext_shutdown = 1'b1;
    step();
    chk("stop_capture_sw", status_word, sw(1, 1, 1, 1, 0, 4'd0, 8'h06));
    ext_shutdown = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && status_word[30] === 1'b1; i++) begin
      cnt++;
      step();
    end
    chk("stop_to_cycles", 32'(cnt), 32'd21);
    chk("stop_to_sw", status_word, sw(0, 0, 0, 1, 1, 4'd0, 8'h0C));
    chk("stop_to_safe", {28'd0, sys_rst, n_sck_pow, shutdown_force, spi_en}, 32'hE);
    spi_running = 1'b0; sys_en = 1'b0;
    step();
    chk("stop_to_exit_sw", status_word, sw(0, 0, 0, 0, 0, 4'd0, 8'h0C));

    // Asynchronous reset in the middle of RUNNING
    start_run();
    #2 rst = 1'b1;
    #1;
    chk("arst_sys_rst", 32'(sys_rst), 32'd1);
    chk("arst_shdn_force", 32'(shutdown_force), 32'd1);
    chk("arst_n_sck_pow", 32'(n_sck_pow), 32'd1);
    chk("arst_dma_spi", {30'd0, dma_en, spi_en}, 32'd0);
    chk("arst_status", status_word, 32'd0);
    step();
    rst = 1'b0; spi_running = 1'b0;
    repeat (5) step();
    chk("arst_no_restart", 32'(n_shutdown_rst), 32'd1);
    chk("arst_idle_sw", status_word, 32'd0);
    sys_en = 1'b0;
    step();
    sys_en = 1'b1;
    step();
    chk("arst_restart_shdn", 32'(n_shutdown_rst), 32'd0);
    chk("arst_restart_sw", status_word, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hw_supervisor.md
HW_SUPERVISOR -- requirements
Module: hw_supervisor

Interface
REQ-001 Parameter N_BOARDS, default 8: number of boards, legal range 1..16.
REQ-002 Parameter BUF_LOAD_WAIT, default 250000000: START_DMA timeout in cycles.
REQ-003 Parameter SPI_START_WAIT, default 250000000: START_SPI timeout in cycles.
REQ-004 Parameter SPI_STOP_WAIT, default 250000000: STOPPING timeout in cycles.
REQ-005 Parameter SHDN_RST_CYCLES, default 16: n_shutdown_rst low-pulse length, legal range 1 or more.
REQ-006 Ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- sys_en  in  1  system enable from PS.
- fault_mask  in  8  per-class ignore; bit k=1 ignores class k+1 of REQ-014; bit 7 reserved, no effect.
- dac_buf_full  in  1  DAC buffer preloaded.
- spi_running  in  1  SPI subsystem running.
- ext_shutdown, shutdown_sense  in  1 each  shutdown requests.
- sense_num  in  4  board reporting shutdown_sense.
- over_thresh, dac_empty_read, adc_full_write, premat_trig, premat_dac_div, premat_adc_div  in  N_BOARDS each  per-board faults.
- sys_rst, dma_en, spi_en, n_sck_pow, shutdown_force, n_shutdown_rst  out  1 each  hardware controls.
- fault_boards  out  N_BOARDS  all boards asserting the captured fault class at the capture cycle.
- status_word  out  32  status word, REQ-020.

Function
REQ-007 States: IDLE, SHDN_RST, START_DMA, START_SPI, RUNNING, STOPPING, HALTED.
REQ-008 Timer: zeroed on every state entry; increments each cycle in timed states.
REQ-009 Timeout rule: a timeout fires on the cycle timer==WAIT with the exit condition still false, giving WAIT+1 observation cycles.
REQ-010 IDLE -> SHDN_RST on sys_en rising edge (sys_en=1, prev_sys_en=0). Actions: sys_rst=0, shutdown_force=0, n_shutdown_rst=0, running=1; status_code, board_num and fault_boards cleared.
REQ-011 SHDN_RST holds for exactly SHDN_RST_CYCLES cycles, then -> START_DMA with n_shutdown_rst=1, dma_en=1.
REQ-012 START_DMA:
- dac_buf_full -> START_SPI with dma_running=1, spi_en=1, n_sck_pow=0.
- Timeout -> HALTED, code 0x02.
- sys_en=0 (priority over both) -> IDLE, code 0x01, safe outputs.
REQ-013 START_SPI:
- spi_running -> RUNNING.
- Timeout -> HALTED, code 0x03.
- sys_en=0 (priority) -> STOPPING, code 0x01.
REQ-014 RUNNING: highest unmasked active cause captured, in priority order:
- sys_en=0: code 0x01, never maskable.
- over_thresh: 0x04.
- shutdown_sense: 0x05, board_num=sense_num.
- ext_shutdown: 0x06.
- dac_empty_read: 0x07.
- adc_full_write: 0x08.
- premat_trig: 0x09.
- premat_dac_div: 0x0A.
- premat_adc_div: 0x0B.
REQ-015 On capture: -> STOPPING, stopping=1, spi_en=0.
- Vector classes: board_num = lowest set bit index; fault_boards = that class's vector.
- Scalar classes: fault_boards=0.
- Simultaneous classes: only the highest priority is recorded.
REQ-016 STOPPING:
- spi_running=0 -> IDLE, safe outputs, code retained.
- Timeout -> HALTED, code 0x0C overwrites.
REQ-017 Safe outputs: sys_rst=1, dma_en=0, dma_running=0, spi_en=0, n_sck_pow=1, shutdown_force=1, running=0, stopping=0. They are applied on every entry to IDLE or HALTED.
REQ-018 HALTED: halted=1. On sys_en=0 -> IDLE with halted=0 and prev_sys_en=0; code retained until the next start.
REQ-019 prev_sys_en tracks sys_en each IDLE cycle, so a sys_en held high after returning to IDLE cannot restart the block.
REQ-020 status_word bit fields:
- [31] running
- [30] stopping
- [29] dma_running
- [28] spi_running (live input)
- [27] halted
- [26:23] board_num
- [22:8] zero
- [7:0] status_code
REQ-021 Faults outside RUNNING are ignored, except as stated in REQ-012 and REQ-013.

Reset
REQ-022 While rst=1:
- state=IDLE, sys_rst=1, shutdown_force=1, n_shutdown_rst=1, n_sck_pow=1.
- dma_en=0, spi_en=0, fault_boards=0, status_word=0.
- prev_sys_en=1, timer=0.
REQ-023 rst asserted in any state, mid-operation, takes effect asynchronously. The block restarts only on a fresh sys_en rising edge after release.

Structure
REQ-024 Package hw_supervisor_pkg holds the state encoding, status codes 0x00–0x0C, and the status_word field positions.
REQ-025 Sub-module lsb_index (parameter WIDTH): outputs the lowest set-bit index and a valid flag. It is instantiated once per vector fault class.

Verification
REQ-026 Nominal start: sys_en 0->1; dac_buf_full after 10 cycles; spi_running after 5 cycles.
- Required response: n_shutdown_rst low for exactly 16 cycles, then RUNNING with status_word=0xA000_0000+0x1000_0000.
REQ-027 Priority fault in RUNNING: over_thresh=0x28 and premat_trig=0x01 in the same cycle.
- Required response: code 0x04, board_num=3, fault_boards=0x28, spi_en=0 next cycle.
- Then spi_running=0 -> IDLE, sys_rst=1.
REQ-028 Masking: fault_mask=0x01 with over_thresh=0x01 and ext_shutdown=1.
- Required response: code 0x06, fault_boards=0.
REQ-029 Timeouts (bench with BUF_LOAD_WAIT=20, SPI_STOP_WAIT=20):
- dac_buf_full held low: HALTED after exactly 21 START_DMA cycles, code 0x02.
- spi_running stuck high in STOPPING: HALTED, code 0x0C.
- sys_en held high in HALTED: stays HALTED.
REQ-030 Reset mid-RUNNING: rst pulsed.
- Required response: all outputs at reset values without waiting for a clock edge.
- sys_en held high after release: no restart until sys_en goes 0 then 1.
